// File: rtl/sync_fifo_pro_if.sv
// Handshake/data bundle for sync_fifo_pro.
// Error flag signals exist only with SYNC_FIFO_PRO_ERR_FLAGS_EN.
interface sync_fifo_pro_if #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 512
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  i_wr_en;
   logic [DATA_WIDTH-1:0] i_wr_data;
   logic                  i_rd_en;
   logic [DATA_WIDTH-1:0] o_rd_data;
   logic                  o_full;
   logic                  o_empty;
   logic                  o_almost_full;
   logic                  o_almost_empty;
   logic [CW-1:0]         o_count;
`ifdef SYNC_FIFO_PRO_ERR_FLAGS_EN
   logic                  o_overflow;
   logic                  o_underflow;
`endif

   modport master (
      output i_wr_en, i_wr_data, i_rd_en,
      input  o_rd_data, o_full, o_empty,
      input  o_almost_full, o_almost_empty, o_count
`ifdef SYNC_FIFO_PRO_ERR_FLAGS_EN
      , input o_overflow, o_underflow
`endif
   );

   modport slave (
      input  i_wr_en, i_wr_data, i_rd_en,
      output o_rd_data, o_full, o_empty,
      output o_almost_full, o_almost_empty, o_count
`ifdef SYNC_FIFO_PRO_ERR_FLAGS_EN
      , output o_overflow, o_underflow
`endif
   );
endinterface

// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO: AF/AE flags, optional FWFT, any DEPTH >= 2.
// Sticky overflow/underflow flags with SYNC_FIFO_PRO_ERR_FLAGS_EN.
module sync_fifo_pro #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 512,
   parameter int AF_THRESH  = DEPTH - 4,
   parameter int AE_THRESH  = 4,
   parameter int FWFT       = 0
) (
   input  logic           i_clk,
   input  logic           i_rst,
   sync_fifo_pro_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam bit LP_FWFT = (FWFT != 0);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_ram_cnt;
   logic                  r_ovld;
   logic [DATA_WIDTH-1:0] r_rd_data;

   logic [AW-1:0]         w_wr_ptr_nxt;
   logic [AW-1:0]         w_rd_ptr_nxt;
   logic [CW-1:0]         w_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic                  w_ram_rd;

   assign w_wr_ptr_nxt = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_ptr_nxt = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

   assign w_count = r_ram_cnt + {{(CW-1){1'b0}}, r_ovld};
   assign w_full  = (w_count == CW'(DEPTH));
   assign w_empty = LP_FWFT ? !r_ovld : (r_ram_cnt == '0);
   assign w_wr_ok = bus.i_wr_en && !w_full;
   assign w_rd_ok = bus.i_rd_en && !w_empty;

   // FWFT refills the output register whenever it is free or being consumed
   assign w_ram_rd = LP_FWFT ?
                     ((!r_ovld || w_rd_ok) && (r_ram_cnt != '0)) :
                     w_rd_ok;

   always_ff @(posedge i_clk) begin
      if (w_wr_ok) r_mem[r_wr_ptr] <= bus.i_wr_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_ram_cnt <= '0;
         r_ovld    <= 1'b0;
         r_rd_data <= '0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= w_wr_ptr_nxt;
         if (w_ram_rd) begin
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_rd_data <= r_mem[r_rd_ptr];
         end
         case ({w_wr_ok, w_ram_rd})
            2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
            2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
            default: r_ram_cnt <= r_ram_cnt;
         endcase
         if (LP_FWFT) begin
            if (w_ram_rd)     r_ovld <= 1'b1;
            else if (w_rd_ok) r_ovld <= 1'b0;
         end
      end
   end

   assign bus.o_rd_data      = r_rd_data;
   assign bus.o_full         = w_full;
   assign bus.o_empty        = w_empty;
   assign bus.o_almost_full  = (w_count >= CW'(AF_THRESH));
   assign bus.o_almost_empty = (w_count <= CW'(AE_THRESH));
   assign bus.o_count        = w_count;

`ifdef SYNC_FIFO_PRO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.i_wr_en && w_full)  r_overflow  <= 1'b1;
         if (bus.i_rd_en && w_empty) r_underflow <= 1'b1;
      end
   end

   assign bus.o_overflow  = r_overflow;
   assign bus.o_underflow = r_underflow;
`endif
endmodule

// File: tb/tb_sync_fifo_pro.sv
// Random/directed bench for sync_fifo_pro: three configurations
// (std D8, std D5, FWFT D4) against a queue-style reference model.
module tb_sync_fifo_pro;
   localparam int DW = 16;
   localparam int DEP [3] = '{8, 5, 4};
   localparam int AF  [3] = '{6, 4, 3};
   localparam int AE  [3] = '{2, 1, 1};
   localparam bit FW  [3] = '{1'b0, 1'b0, 1'b1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          wr  [3];
   logic          rd  [3];
   logic [DW-1:0] din [3];
   logic [DW-1:0] dout [3];
   logic [7:0]    cnt [3];
   logic          full [3];
   logic          emp [3];
   logic          af [3];
   logic          ae [3];
   logic          ovf [3];
   logic          udf [3];

   int checks   = 0;
   int failures = 0;

   sync_fifo_pro_if #(.DATA_WIDTH(DW), .DEPTH(8)) if0 ();
   sync_fifo_pro_if #(.DATA_WIDTH(DW), .DEPTH(5)) if1 ();
   sync_fifo_pro_if #(.DATA_WIDTH(DW), .DEPTH(4)) if2 ();

   sync_fifo_pro #(.DATA_WIDTH(DW), .DEPTH(8), .AF_THRESH(6),
                   .AE_THRESH(2), .FWFT(0))
      u0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
   sync_fifo_pro #(.DATA_WIDTH(DW), .DEPTH(5), .AF_THRESH(4),
                   .AE_THRESH(1), .FWFT(0))
      u1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
   sync_fifo_pro #(.DATA_WIDTH(DW), .DEPTH(4), .AF_THRESH(3),
                   .AE_THRESH(1), .FWFT(1))
      u2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));

   assign if0.i_wr_en = wr[0];
   assign if0.i_rd_en = rd[0];
   assign if0.i_wr_data = din[0];
   assign if1.i_wr_en = wr[1];
   assign if1.i_rd_en = rd[1];
   assign if1.i_wr_data = din[1];
   assign if2.i_wr_en = wr[2];
   assign if2.i_rd_en = rd[2];
   assign if2.i_wr_data = din[2];

   assign dout[0] = if0.o_rd_data;
   assign dout[1] = if1.o_rd_data;
   assign dout[2] = if2.o_rd_data;
   assign cnt[0] = 8'(if0.o_count);
   assign cnt[1] = 8'(if1.o_count);
   assign cnt[2] = 8'(if2.o_count);
   assign full[0] = if0.o_full;
   assign full[1] = if1.o_full;
   assign full[2] = if2.o_full;
   assign emp[0] = if0.o_empty;
   assign emp[1] = if1.o_empty;
   assign emp[2] = if2.o_empty;
   assign af[0] = if0.o_almost_full;
   assign af[1] = if1.o_almost_full;
   assign af[2] = if2.o_almost_full;
   assign ae[0] = if0.o_almost_empty;
   assign ae[1] = if1.o_almost_empty;
   assign ae[2] = if2.o_almost_empty;
`ifdef SYNC_FIFO_PRO_ERR_FLAGS_EN
   assign ovf[0] = if0.o_overflow;
   assign ovf[1] = if1.o_overflow;
   assign ovf[2] = if2.o_overflow;
   assign udf[0] = if0.o_underflow;
   assign udf[1] = if1.o_underflow;
   assign udf[2] = if2.o_underflow;
`else
   assign ovf[0] = 1'b0;
   assign ovf[1] = 1'b0;
   assign ovf[2] = 1'b0;
   assign udf[0] = 1'b0;
   assign udf[1] = 1'b0;
   assign udf[2] = 1'b0;
`endif

   // reference model: ordered word list, FWFT head register, sticky errs
   logic [DW-1:0] mw [3][8];
   int            mn [3];
   bit            mov [3];
   logic [DW-1:0] mo [3];
   bit            movf [3];
   bit            mudf [3];

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_count(int k);
      return mn[k] + (FW[k] ? int'(mov[k]) : 0);
   endfunction

   function automatic logic [DW-1:0] m_pop(int k);
      logic [DW-1:0] r;
      r = mw[k][0];
      for (int i = 0; i < 7; i++) mw[k][i] = mw[k][i+1];
      mn[k]--;
      return r;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 3; k++) begin
         mn[k] = 0;
         mov[k] = 1'b0;
         mo[k] = '0;
         movf[k] = 1'b0;
         mudf[k] = 1'b0;
      end
   endtask

   task automatic m_step(int k);
      int c;
      bit f, e, wok, rok, ld;
      c = m_count(k);
      f = (c == DEP[k]);
      e = FW[k] ? !mov[k] : (c == 0);
      wok = wr[k] && !f;
      rok = rd[k] && !e;
      if (wr[k] && f) movf[k] = 1'b1;
      if (rd[k] && e) mudf[k] = 1'b1;
      if (FW[k]) begin
         ld = (!mov[k] || rok) && (mn[k] > 0);
         if (ld) begin
            mo[k] = m_pop(k);
            mov[k] = 1'b1;
         end else if (rok) begin
            mov[k] = 1'b0;
         end
      end else if (rok) begin
         mo[k] = m_pop(k);
      end
      if (wok) begin
         mw[k][mn[k]] = din[k];
         mn[k]++;
      end
   endtask

   task automatic check_all();
      int c;
      for (int k = 0; k < 3; k++) begin
         c = m_count(k);
         check($sformatf("u%0d.count", k), 32'(cnt[k]), 32'(c));
         check($sformatf("u%0d.full", k), 32'(full[k]),
               32'(c == DEP[k]));
         check($sformatf("u%0d.empty", k), 32'(emp[k]),
               32'(FW[k] ? !mov[k] : (c == 0)));
         check($sformatf("u%0d.afull", k), 32'(af[k]), 32'(c >= AF[k]));
         check($sformatf("u%0d.aempty", k), 32'(ae[k]), 32'(c <= AE[k]));
         check($sformatf("u%0d.rdata", k), 32'(dout[k]), 32'(mo[k]));
`ifdef SYNC_FIFO_PRO_ERR_FLAGS_EN
         check($sformatf("u%0d.ovf", k), 32'(ovf[k]), 32'(movf[k]));
         check($sformatf("u%0d.udf", k), 32'(udf[k]), 32'(mudf[k]));
`endif
      end
   endtask

   task automatic set_all(bit w, bit r, logic [DW-1:0] d);
      for (int k = 0; k < 3; k++) begin
         wr[k] = w;
         rd[k] = r;
         din[k] = d;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      for (int k = 0; k < 3; k++) m_step(k);
      #1 check_all();
      @(negedge clk);
   endtask

   task automatic async_rst();
      #2 rst = 1'b1;
      #1 m_reset();
      check_all();
      @(posedge clk);
      #1 check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int pw, pr;
      set_all(1'b0, 1'b0, '0);
      m_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;

      for (int i = 1; i <= 10; i++) begin
         set_all(1'b1, 1'b0, DW'(i));
         cyc();
      end
      for (int i = 0; i < 10; i++) begin
         set_all(1'b0, 1'b1, '0);
         cyc();
      end
      set_all(1'b1, 1'b0, 16'h00AB);
      cyc();
      set_all(1'b1, 1'b0, 16'h00CD);
      cyc();
      for (int i = 0; i < 20; i++) begin
         set_all(1'b1, 1'b1, DW'($urandom));
         cyc();
      end
      set_all(1'b1, 1'b1, 16'h1234);
      async_rst();

      for (int i = 0; i < 10; i++) begin
         set_all(1'b1, 1'b0, DW'(16'h100 + i));
         cyc();
      end
      set_all(1'b1, 1'b1, 16'hDEAD);
      cyc();
      set_all(1'b0, 1'b0, '0);
      cyc();
      cyc();

      pw = 50;
      pr = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
         end
         for (int k = 0; k < 3; k++) begin
            wr[k] = ($urandom_range(0, 99) < pw);
            rd[k] = ($urandom_range(0, 99) < pr);
            din[k] = DW'($urandom);
         end
         if (n == 1500) async_rst();
         else cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sync_fifo_pro.md
# sync_fifo_pro

Parametrised single-clock FIFO that succeeds the basic synchronous FIFO. It adds programmable almost-full/almost-empty flags, a selectable first-word-fall-through (FWFT) read mode, and support for non-power-of-two depths. It sits between producer and consumer stages in the same clock domain, for example stream buffering ahead of a packetiser. Optional sticky overflow/underflow error flags are compiled in by macro.

## Interface
Parameters:
- DATA_WIDTH, 64, word width in bits.
- DEPTH, 512, number of storage words; any integer ≥ 2, power of two not required.
- AF_THRESH, DEPTH-4, o_almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 4, o_almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard (registered read, latency 1); 1 = first-word-fall-through.

Ports (CW = $clog2(DEPTH)+1):
- i_clk  in  1  sole clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_wr_en  in  1  write request.
- i_wr_data  in  DATA_WIDTH  write word.
- i_rd_en  in  1  read request (standard mode) / consume acknowledge (FWFT mode).
- o_rd_data  out  DATA_WIDTH  read word.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  no word available to read.
- o_almost_full  out  1  count ≥ AF_THRESH.
- o_almost_empty  out  1  count ≤ AE_THRESH.
- o_count  out  CW  words held, including any FWFT output-register word.
- o_overflow  out  1  sticky; present only with SYNC_FIFO_PRO_ERR_FLAGS_EN.
- o_underflow  out  1  sticky; present only with SYNC_FIFO_PRO_ERR_FLAGS_EN.

## Operation
- Write acceptance: wr_ok = i_wr_en && !o_full. A write while full is dropped even if a read occurs in the same cycle.
- Read acceptance: rd_ok = i_rd_en && !o_empty.
- Storage: register array; wr_ptr/rd_ptr width $clog2(DEPTH); each pointer wraps from DEPTH-1 to 0.
- Count update:
  - wr_ok only: +1.
  - rd_ok only: −1.
  - Both: unchanged.
  - Count never exceeds DEPTH and never goes below 0.
- Flags decode combinationally from the registered count: o_full, o_almost_full, o_almost_empty.
- Standard mode (FWFT=0):
  - o_empty = (count == 0).
  - On rd_ok, o_rd_data ← ram[rd_ptr] and rd_ptr advances.
  - o_rd_data holds its value otherwise.
- FWFT mode (FWFT=1):
  - A one-word output register with a valid bit (ovld) presents the head word on o_rd_data.
  - o_empty = !ovld.
  - When ovld is clear, or rd_ok occurs, and RAM holds a word, the output register loads ram[rd_ptr] and rd_ptr advances.
  - o_count = RAM words + ovld.
  - o_full is based on o_count == DEPTH. RAM plus output register never exceed DEPTH.
- Reset (asynchronous, active-high), any cycle including mid-transfer:
  - Pointers, count and ovld → 0; o_rd_data → 0.
  - o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_count=0, error flags=0.
  - RAM contents are not reset and are not read back.

## Timing
- Write at edge N: o_count and flags reflect it after edge N.
- Standard mode:
  - o_empty deasserts after edge N.
  - rd_en asserted in cycle N+1 → data on o_rd_data after edge N+1.
- FWFT mode:
  - The word reaches the output register at edge N+1; o_empty deasserts after edge N+1.
  - Data is valid with !o_empty, with no rd_en needed.
  - Back-to-back rd_en sustains one word per cycle while the RAM is non-empty.
- Simultaneous read and write at count 0:
  - Read is rejected because o_empty=1; write is accepted.
  - In FWFT mode the written word still obeys the 2-cycle visibility.
- Simultaneous read and write at count DEPTH: read accepted, write dropped, count → DEPTH−1.
- Pointer wrap is seamless; there is no bubble at the DEPTH−1 → 0 transition.

## Configuration
- SYNC_FIFO_PRO_ERR_FLAGS_EN defined:
  - o_overflow sets on the edge after i_wr_en && o_full.
  - o_underflow sets on the edge after i_rd_en && o_empty.
  - Both stay set until i_rst.
- Undefined: the o_overflow/o_underflow ports and their logic are absent. Dropped requests are silently ignored.

## Test plan
- Reset, DEPTH=8, FWFT=0: check o_empty=1, o_full=0, o_almost_empty=1, o_count=0, o_rd_data=0. Assert i_rst mid-burst → same values on the same cycle, asynchronously.
- DEPTH=8, AF=6, AE=2, FWFT=0: write 0x1..0x8 → o_almost_full rises at count 6 and o_full at 8; a 9th write is dropped. Read 8 → 0x1..0x8 in order, each 1 cycle after rd_en; o_almost_empty rises at count 2.
- DEPTH=5 (non-power-of-two): 20 continuous simultaneous writes/reads at steady count 2 → pointers wrap 4→0, data order preserved, o_count constant at 2.
- FWFT=1, DEPTH=4: single write 0xAB at edge N → o_empty low and o_rd_data=0xAB after edge N+1. Fill to 4 → o_full=1 and o_count=4. Continuous rd_en drains one word per cycle in order.
- Full + simultaneous read/write, DEPTH=4: write dropped, read returns the oldest word, o_count=3.
- With SYNC_FIFO_PRO_ERR_FLAGS_EN: write when full → o_overflow=1 and held; read when empty → o_underflow=1 and held; i_rst clears both.
